// File: rtl/pad_ownership_arbiter.sv
// Round-robin owner arbiter for one shared bidirectional pad cell.
// A driver-off turnaround window separates consecutive owners so their drivers never overlap.
module pad_ownership_arbiter #(
    parameter int                 NUM_REQ    = 2,
    parameter int                 PADATTR    = 16,
    parameter int                 TURNAROUND = 1,
    parameter logic [PADATTR-1:0] IDLE_ATTR  = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    input  logic [NUM_REQ-1:0]         out_i,
    input  logic [NUM_REQ-1:0]         oe_i,
    input  logic [NUM_REQ*PADATTR-1:0] attr_i,
    output logic                       pad_in_o,
    output logic                       pad_oe_o,
    output logic [PADATTR-1:0]         pad_attributes_o,
    input  logic                       pad_out_i,
    output logic [NUM_REQ-1:0]         in_o,
    output logic                       busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic [3:0]           cnt_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]     pickIdx;
    logic                 pickValid;

    // Scan from the highest offset down so the request closest to the pointer wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                pickValid = 1'b1;
                pickIdx   = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    assign ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        owner_q <= pickIdx;
                        gnt_q   <= NUM_REQ'(1) << pickIdx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // Owner keeps the pad until it drops its own request; no preemption.
                    if (!req_i[owner_q]) begin
                        gnt_q <= '0;
                        ptr_q <= ptr_d;
                        if (TURNAROUND > 0) begin
                            cnt_q   <= TURN_LOAD;
                            state_q <= TURN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                TURN: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q != IDLE);

    always_comb begin
        pad_in_o         = 1'b0;
        pad_oe_o         = 1'b0;
        pad_attributes_o = IDLE_ATTR;
        in_o             = '0;
        if (state_q == GRANT) begin
            pad_in_o         = out_i[owner_q];
            pad_oe_o         = oe_i[owner_q];
            pad_attributes_o = attr_i[int'(owner_q)*PADATTR +: PADATTR];
            in_o[owner_q]    = pad_out_i;
        end
    end

endmodule
